// File: rtl/food_spawner.sv
// food_spawner: picks a free playfield cell for the snake's food.
// Random candidates come from the 5-bit LFSR stream by rejection sampling and
// are checked against the snake body through an occupancy request/ack handshake.
// After MAX_TRIES occupied candidates, a row-major linear scan takes over.
// If the scan finds every cell occupied, the block parks in FULL until reset.
module food_spawner #(
    parameter int GRID_W    = 32,
    parameter int GRID_H    = 24,
    parameter int MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rnd,
    input  logic       spawn,
    output logic       occ_req,
    output logic [4:0] occ_x,
    output logic [4:0] occ_y,
    input  logic       occ_ack,
    input  logic       occ_hit,
    output logic [4:0] food_x,
    output logic [4:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       board_full
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAW_X = 3'd1;
    localparam logic [2:0] S_DRAW_Y = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_SCAN   = 3'd4;
    localparam logic [2:0] S_FULL   = 3'd5;

    // Bounds are widened by one bit so GRID_W/GRID_H = 32 still compare correctly.
    localparam logic [5:0]  W_LIM  = 6'(GRID_W);
    localparam logic [5:0]  H_LIM  = 6'(GRID_H);
    localparam logic [4:0]  X_LAST = 5'(GRID_W - 1);
    localparam logic [4:0]  Y_LAST = 5'(GRID_H - 1);
    localparam logic [10:0] CELLS  = 11'(GRID_W * GRID_H);
    localparam logic [8:0]  TRIES  = 9'(MAX_TRIES);

    logic [2:0]  state, state_d;
    logic [4:0]  cand_x, cand_y;
    logic [4:0]  nxt_x, nxt_y;
    logic [7:0]  try_cnt;
    logic [9:0]  scan_cnt;
    logic [8:0]  tries_inc;
    logic [10:0] scan_inc;

    logic x_ok, y_ok;
    logic in_query;      // CHECK or SCAN: states that talk to the occupancy table
    logic issue;         // first cycle of a query: load coordinates, raise occ_req
    logic hit_ack, free_ack;
    logic retry, to_scan, scan_step, scan_done, commit;

    assign x_ok      = {1'b0, rnd} < W_LIM;
    assign y_ok      = {1'b0, rnd} < H_LIM;
    assign tries_inc = {1'b0, try_cnt} + 9'd1;
    assign scan_inc  = {1'b0, scan_cnt} + 11'd1;

    // An ack only counts while a query is actually outstanding.
    assign in_query  = (state == S_CHECK) || (state == S_SCAN);
    assign issue     = in_query && !occ_req;
    assign hit_ack   = in_query && occ_req && occ_ack && occ_hit;
    assign free_ack  = in_query && occ_req && occ_ack && !occ_hit;
    assign commit    = free_ack;
    assign retry     = (state == S_CHECK) && hit_ack && (tries_inc < TRIES);
    assign to_scan   = (state == S_CHECK) && hit_ack && !(tries_inc < TRIES);
    assign scan_step = (state == S_SCAN) && hit_ack && (scan_inc != CELLS);
    assign scan_done = (state == S_SCAN) && hit_ack && (scan_inc == CELLS);

    // Row-major successor of the current candidate, wrapping at both edges.
    always_comb begin
        nxt_x = cand_x + 5'd1;
        nxt_y = cand_y;
        if (cand_x == X_LAST) begin
            nxt_x = 5'd0;
            nxt_y = (cand_y == Y_LAST) ? 5'd0 : cand_y + 5'd1;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:   if (spawn) state_d = S_DRAW_X;
            S_DRAW_X: if (x_ok)  state_d = S_DRAW_Y;
            S_DRAW_Y: if (y_ok)  state_d = S_CHECK;
            S_CHECK: begin
                if (commit)       state_d = S_IDLE;
                else if (retry)   state_d = S_DRAW_X;
                else if (to_scan) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (commit)         state_d = S_IDLE;
                else if (scan_done) state_d = S_FULL;
            end
            S_FULL:   state_d = S_FULL;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register and busy flag; reset lands in DRAW_X so food appears unprompted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DRAW_X;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != S_IDLE) && (state_d != S_FULL);
        end
    end

    // Candidate latching from the random stream and scan advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_x <= 5'd0;
            cand_y <= 5'd0;
        end else if (state == S_DRAW_X && x_ok) begin
            cand_x <= rnd;
        end else if (state == S_DRAW_Y && y_ok) begin
            cand_y <= rnd;
        end else if (to_scan || scan_step) begin
            cand_x <= nxt_x;
            cand_y <= nxt_y;
        end
    end

    // Try and scan counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            try_cnt  <= 8'd0;
            scan_cnt <= 10'd0;
        end else begin
            if (state == S_IDLE && spawn)
                try_cnt <= 8'd0;
            else if (retry || to_scan)
                try_cnt <= tries_inc[7:0];
            if (to_scan)
                scan_cnt <= 10'd0;
            else if (scan_step)
                scan_cnt <= scan_inc[9:0];
        end
    end

    // Occupancy query port: coordinates stay put until the ack; in SCAN a hit
    // rolls straight into the next cell without dropping occ_req.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_req <= 1'b0;
            occ_x   <= 5'd0;
            occ_y   <= 5'd0;
        end else if (issue) begin
            occ_req <= 1'b1;
            occ_x   <= cand_x;
            occ_y   <= cand_y;
        end else if (scan_step) begin
            occ_x   <= nxt_x;
            occ_y   <= nxt_y;
        end else if (commit || retry || to_scan || scan_done) begin
            occ_req <= 1'b0;
        end
    end

    // Committed food cell and the sticky board-full flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            food_x     <= 5'd0;
            food_y     <= 5'd0;
            food_valid <= 1'b0;
            board_full <= 1'b0;
        end else begin
            if (state == S_IDLE && spawn)
                food_valid <= 1'b0;
            else if (commit) begin
                food_x     <= cand_x;
                food_y     <= cand_y;
                food_valid <= 1'b1;
            end
            if (scan_done)
                board_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: stimulus pushes expected queries and
// commits; negedge monitors answer queries and pop/compare expectations.
module tb_food_spawner;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       hit;
    } qry_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main DUT: 32x24, two random tries
    logic       rst, spawn, occ_ack, occ_hit;
    logic [4:0] rnd = 5'd0;
    logic       occ_req, food_valid, busy, board_full;
    logic [4:0] occ_x, occ_y, food_x, food_y;

    // small DUT: 2x2, one random try, used for board-full
    logic       rst_s, spawn_s, ack_s, hit_s;
    logic [4:0] rnd_s;
    logic       req_s, fv_s, busy_s, full_s;
    logic [4:0] ox_s, oy_s, fx_s, fy_s;

    qry_t       q_exp[$];
    qry_t       s_exp[$];
    logic [9:0] f_exp[$];
    logic [4:0] rnd_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int ack_dly = 0;
    int wcnt = 0;
    logic fv_prev = 1'b0;

    food_spawner #(.GRID_W(32), .GRID_H(24), .MAX_TRIES(2)) dut (
        .clk(clk), .rst(rst), .rnd(rnd), .spawn(spawn),
        .occ_req(occ_req), .occ_x(occ_x), .occ_y(occ_y),
        .occ_ack(occ_ack), .occ_hit(occ_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .board_full(board_full)
    );

    food_spawner #(.GRID_W(2), .GRID_H(2), .MAX_TRIES(1)) dut_s (
        .clk(clk), .rst(rst_s), .rnd(rnd_s), .spawn(spawn_s),
        .occ_req(req_s), .occ_x(ox_s), .occ_y(oy_s),
        .occ_ack(ack_s), .occ_hit(hit_s),
        .food_x(fx_s), .food_y(fy_s), .food_valid(fv_s),
        .busy(busy_s), .board_full(full_s)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic push_q(input int x, input int y, input bit hit);
        qry_t e;
        e.x = 5'(x); e.y = 5'(y); e.hit = hit;
        q_exp.push_back(e);
    endtask

    task automatic push_s(input int x, input int y);
        qry_t e;
        e.x = 5'(x); e.y = 5'(y); e.hit = 1'b1;
        s_exp.push_back(e);
    endtask

    task automatic push_f(input int x, input int y);
        f_exp.push_back({5'(x), 5'(y)});
    endtask

    task automatic wait_req(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (occ_req) return;
        end
        fail_now("wait_req");
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (q_exp.size() == 0 && f_exp.size() == 0) return;
        end
        fail_now("drain");
    endtask

    // rnd stream: one queued value per cycle, last value held
    always @(posedge clk) begin
        #1;
        if (rnd_q.size() > 0) rnd = rnd_q.pop_front();
    end

    // main occupancy model + query/commit scoreboard
    always @(negedge clk) begin
        qry_t e;
        logic [9:0] f;
        occ_ack = 1'b0;
        occ_hit = 1'b0;
        if (rst || !occ_req) begin
            wcnt = 0;
        end else if (wcnt < ack_dly) begin
            wcnt++;
        end else begin
            wcnt = 0;
            occ_ack = 1'b1;
            if (q_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL query_unexpected: got (%0d,%0d) expected none", occ_x, occ_y);
            end else begin
                e = q_exp.pop_front();
                chk("query_x", 32'(occ_x), 32'(e.x));
                chk("query_y", 32'(occ_y), 32'(e.y));
                occ_hit = e.hit;
            end
        end
        if (!rst && food_valid && !fv_prev) begin
            if (f_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL commit_unexpected: got (%0d,%0d) expected none", food_x, food_y);
            end else begin
                f = f_exp.pop_front();
                chk("food_x", 32'(food_x), 32'(f[9:5]));
                chk("food_y", 32'(food_y), 32'(f[4:0]));
            end
        end
        fv_prev = food_valid;
    end

    // small-board model: every cell is occupied, zero-wait ack
    always @(negedge clk) begin
        qry_t e;
        ack_s = 1'b0;
        hit_s = 1'b0;
        if (!rst_s && req_s) begin
            ack_s = 1'b1;
            hit_s = 1'b1;
            if (s_exp.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL small_query_unexpected: got (%0d,%0d) expected none", ox_s, oy_s);
            end else begin
                e = s_exp.pop_front();
                chk("small_query_x", 32'(ox_s), 32'(e.x));
                chk("small_query_y", 32'(oy_s), 32'(e.y));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; spawn = 1'b0;
        rst_s = 1'b1; spawn_s = 1'b0; rnd_s = 5'd1;

        // reset and automatic first spawn: (7,5), 4 cycles after rst falls
        rnd_q.push_back(5'd7);
        push_q(7, 5, 0); push_f(7, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {occ_req, occ_x, occ_y, food_x, food_y, food_valid, busy, board_full}, 32'd0);
        rst = 1'b0;
        rnd_q.push_back(5'd5);
        repeat (3) @(posedge clk);
        #1 chk("first_food_early", 32'(food_valid), 32'd0);
        @(posedge clk);
        #1 chk("first_food_latency", 32'(food_valid), 32'd1);
        drain(20);

        // rejection sampling on Y: 3, 30, 26, 12 -> (3,12)
        @(negedge clk);
        spawn = 1'b1;
        rnd_q.push_back(5'd3); rnd_q.push_back(5'd30);
        rnd_q.push_back(5'd26); rnd_q.push_back(5'd12);
        push_q(3, 12, 0); push_f(3, 12);
        @(posedge clk);
        #1 chk("fv_falls_on_spawn", 32'(food_valid), 32'd0);
        chk("busy_during_spawn", 32'(busy), 32'd1);
        @(negedge clk);
        spawn = 1'b0;
        drain(30);
        @(negedge clk);
        chk("busy_after_commit", 32'(busy), 32'd0);

        // retry: (1,1) hit, (2,2) free
        spawn = 1'b1;
        rnd_q.push_back(5'd1);
        push_q(1, 1, 1); push_q(2, 2, 0); push_f(2, 2);
        @(negedge clk);
        spawn = 1'b0;
        wait_req(20);
        rnd_q.push_back(5'd2);
        drain(40);

        // scan fallback with wrap: (5,5) hit, (31,23) hit, scan (0,0) hit, (1,0) free
        @(negedge clk);
        spawn = 1'b1;
        rnd_q.push_back(5'd5);
        push_q(5, 5, 1); push_q(31, 23, 1); push_q(0, 0, 1); push_q(1, 0, 0);
        push_f(1, 0);
        @(negedge clk);
        spawn = 1'b0;
        wait_req(20);
        rnd_q.push_back(5'd31); rnd_q.push_back(5'd23);
        drain(40);

        // spawn pulsed while a delayed query is pending is ignored
        ack_dly = 3;
        @(negedge clk);
        spawn = 1'b1;
        rnd_q.push_back(5'd9);
        push_q(9, 9, 0); push_f(9, 9);
        @(negedge clk);
        spawn = 1'b0;
        wait_req(20);
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
        drain(40);
        repeat (10) @(negedge clk);
        chk("busy_spawn_ignored", 32'(busy), 32'd0);
        chk("fv_spawn_ignored", 32'(food_valid), 32'd1);

        // reset while a query is outstanding aborts it; auto-spawn restarts
        ack_dly = 5;
        spawn = 1'b1;
        rnd_q.push_back(5'd4);
        push_q(4, 4, 0); push_f(4, 4);
        @(negedge clk);
        spawn = 1'b0;
        wait_req(20);
        rst = 1'b1;
        @(posedge clk);
        #1 chk("rst_drops_req", 32'(occ_req), 32'd0);
        chk("rst_clears_fv", 32'(food_valid), 32'd0);
        q_exp.delete(); f_exp.delete();
        ack_dly = 0;
        push_q(4, 4, 0); push_f(4, 4);
        @(negedge clk);
        rst = 1'b0;
        drain(30);
        @(negedge clk);
        chk("restart_fv", 32'(food_valid), 32'd1);

        // board full on 2x2: (1,1) then scan (0,0),(1,0),(0,1),(1,1)
        push_s(1, 1); push_s(0, 0); push_s(1, 0); push_s(0, 1); push_s(1, 1);
        @(negedge clk);
        rst_s = 1'b0;
        for (int i = 0; i < 40 && !full_s; i++) @(negedge clk);
        chk("board_full_set", 32'(full_s), 32'd1);
        chk("board_full_fv", 32'(fv_s), 32'd0);
        chk("board_full_queries_left", 32'(s_exp.size()), 32'd0);
        chk("board_full_busy", 32'(busy_s), 32'd0);
        spawn_s = 1'b1;
        @(negedge clk);
        spawn_s = 1'b0;
        repeat (10) @(negedge clk);
        chk("board_full_sticky", {29'd0, full_s, fv_s, req_s}, 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
